// File: rtl/jtag_seq_pkg.sv
// jtag_seq_pkg: shared types and constants for the JTAG sequencer.
//   op_e    : command opcodes carried on cmd_op (values 4..7 are reserved)
//   state_e : controller states
//   MAX_BITS_DEF : default command data width
//   LEN_W   : width of the cmd_len field
package jtag_seq_pkg;

  localparam int MAX_BITS_DEF  = 32;
  localparam int LEN_W         = 6;
  // Test-logic-reset walk: five TMS=1 periods, then one TMS=0 period
  localparam int RESET_PERIODS = 6;
  localparam int RESET_TMS_HI  = 5;

  typedef enum logic [2:0] {
    OP_RESET         = 3'd0,
    OP_TMS_SEQ       = 3'd1,
    OP_SCAN          = 3'd2,
    OP_SCAN_FLIP_TMS = 3'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RESET   = 3'd1,
    ST_TMS_SEQ = 3'd2,
    ST_SCAN    = 3'd3,
    ST_RESP    = 3'd4
  } state_e;

  function automatic logic op_is_legal(input logic [2:0] op);
    return (op <= 3'd3);
  endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// jtag_tck_gen: TCK divider. While en is high, tck runs a low phase of
// TCK_DIV clk cycles followed by a high phase of TCK_DIV cycles; while en is
// low the divider is held cleared with tck low.
//   clk, rst    : system clock, asynchronous active-high reset
//   en          : run the divider
//   start       : command accepted this cycle (first low phase begins)
//   tck         : registered TCK output
//   rise, fall  : the closing edge of this cycle toggles tck up / down
//   phase_start : the closing edge of this cycle begins a low phase
module jtag_tck_gen #(
  parameter int TCK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic start,
  output logic tck,
  output logic rise,
  output logic fall,
  output logic phase_start
);

  localparam logic [7:0] CNT_LAST = 8'(TCK_DIV - 1);

  logic [7:0] cnt;
  logic       wrap;

  assign wrap        = en && (cnt == CNT_LAST);
  assign rise        = wrap && !tck;
  assign fall        = wrap && tck;
  assign phase_start = start || fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (wrap) begin
      cnt <= '0;
      tck <= ~tck;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/jtag_seq_ctrl.sv
// jtag_seq_ctrl: command-driven JTAG sequencer. Accepts RESET, TMS_SEQ, SCAN
// and SCAN_FLIP_TMS commands, drives tck/tms/tdi and returns captured TDO for
// scans through a valid/ready response channel.
//   clk, rst                  : system clock, asynchronous active-high reset
//   cmd_valid/cmd_ready       : command handshake
//   cmd_op, cmd_len, cmd_data : opcode, bit count (0 = MAX_BITS), payload
//   rsp_valid/rsp_ready       : scan response handshake
//   rsp_data                  : captured TDO, LSB first
//   tck, tms, tdi, tdo        : JTAG pins
//   busy                      : high outside IDLE
// Build option: define JTAG_SEQ_TDO_SYNC_EN to pass tdo through a 2-flop
// synchronizer and capture on the last clk cycle of the TCK high phase
// (needs TCK_DIV >= 3). Default: tdo sampled on the tck rising edge.
module jtag_seq_ctrl
  import jtag_seq_pkg::*;
#(
  parameter int TCK_DIV  = 4,
  parameter int MAX_BITS = MAX_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [2:0]          cmd_op,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic [MAX_BITS-1:0] cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [MAX_BITS-1:0] rsp_data,
  output logic                tck,
  output logic                tms,
  output logic                tdi,
  input  logic                tdo,
  output logic                busy
);

  localparam int IW = (MAX_BITS > 8) ? $clog2(MAX_BITS) : 3;

  state_e              state;
  logic [IW-1:0]       idx_q, last_q, idx_n, cmd_last;
  logic [MAX_BITS-1:0] data_q, rsp_q;
  logic                flip_q, done_q;
  logic                start, gen_en;
  logic                rise, fall, phase_start;
  logic                cap_stb, tdo_cap;

  // A legal command is only ever taken in IDLE, since cmd_ready is IDLE-only
  assign start  = cmd_valid && cmd_ready && op_is_legal(cmd_op);
  assign idx_n  = idx_q + IW'(1);
  // done_q marks the one cycle between the last falling edge and RESP;
  // the divider is parked there so tck cannot rise again
  assign gen_en = (state == ST_RESET) || (state == ST_TMS_SEQ) ||
                  ((state == ST_SCAN) && !done_q);
  assign rsp_data = rsp_q;

  // Out-of-range lengths are clamped to a full-width command
  always_comb begin
    cmd_last = IW'(MAX_BITS - 1);
    if ((cmd_len != '0) && (int'(cmd_len) <= MAX_BITS))
      cmd_last = IW'(cmd_len - 1'b1);
  end

  jtag_tck_gen #(
    .TCK_DIV(TCK_DIV)
  ) u_tck_gen (
    .clk        (clk),
    .rst        (rst),
    .en         (gen_en),
    .start      (start),
    .tck        (tck),
    .rise       (rise),
    .fall       (fall),
    .phase_start(phase_start)
  );

`ifdef JTAG_SEQ_TDO_SYNC_EN
  logic tdo_s1, tdo_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tdo_s1 <= 1'b0;
      tdo_s2 <= 1'b0;
    end else begin
      tdo_s1 <= tdo;
      tdo_s2 <= tdo_s1;
    end
  end

  assign cap_stb = fall;
  assign tdo_cap = tdo_s2;
`else
  assign cap_stb = rise;
  assign tdo_cap = tdo;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      tms       <= 1'b0;
      tdi       <= 1'b0;
      idx_q     <= '0;
      last_q    <= '0;
      flip_q    <= 1'b0;
      done_q    <= 1'b0;
      data_q    <= '0;
      rsp_q     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          cmd_ready <= 1'b1;
          // Reserved opcodes are accepted by the handshake and dropped here
          if (start) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            idx_q     <= '0;
            data_q    <= cmd_data;
            rsp_q     <= '0;
            done_q    <= 1'b0;
            flip_q    <= (cmd_op == OP_SCAN_FLIP_TMS);
            case (op_e'(cmd_op))
              OP_RESET: begin
                state  <= ST_RESET;
                last_q <= IW'(RESET_PERIODS - 1);
                tms    <= 1'b1;
                tdi    <= 1'b0;
              end
              OP_TMS_SEQ: begin
                state  <= ST_TMS_SEQ;
                last_q <= cmd_last;
                tms    <= cmd_data[0];
                tdi    <= 1'b0;
              end
              default: begin
                state  <= ST_SCAN;
                last_q <= cmd_last;
                tdi    <= cmd_data[0];
                tms    <= (cmd_op == OP_SCAN_FLIP_TMS) && (cmd_last == '0);
              end
            endcase
          end
        end

        ST_RESET, ST_TMS_SEQ: begin
          if (fall && (idx_q == last_q)) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            tms       <= 1'b0;
          end else if (phase_start) begin
            idx_q <= idx_n;
            tms   <= (state == ST_RESET) ? (idx_n < IW'(RESET_TMS_HI))
                                         : data_q[idx_n];
          end
        end

        ST_SCAN: begin
          if (cap_stb)
            rsp_q[idx_q] <= tdo_cap;
          if (done_q) begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            done_q    <= 1'b0;
          end else if (fall && (idx_q == last_q)) begin
            done_q <= 1'b1;
            tms    <= 1'b0;
            tdi    <= 1'b0;
          end else if (phase_start) begin
            idx_q <= idx_n;
            tdi   <= data_q[idx_n];
            tms   <= flip_q && (idx_n == last_q);
          end
        end

        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
